// File: rtl/timer_core.sv
// timer_core: 64-bit free-running timer with compare, sticky interrupt status
// and a debug halt handshake.
//
// Ports
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   count_en                single-cycle increment strobe from the prescaler
//   timer_en                timer enable; a 1->0 transition clears the counter
//   wdata                   32-bit register write data
//   wr_cnt_lo/hi            write strobes for cnt[31:0] / cnt[63:32]
//   wr_cmp_lo/hi            write strobes for cmp[31:0] / cmp[63:32]
//   wr_int_st               interrupt status write; wdata[0]=1 clears
//   int_en                  interrupt output mask
//   dbg_mode, halt_req      debug halt request qualifiers
//   cnt, cmp                counter and compare registers
//   int_st                  sticky compare-match status
//   tim_int                 int_st gated by int_en (combinational)
//   halt_ack                asserted while the counter is halted
module timer_core #(
  parameter logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        count_en,
  input  logic        timer_en,
  input  logic [31:0] wdata,
  input  logic        wr_cnt_lo,
  input  logic        wr_cnt_hi,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic        wr_int_st,
  input  logic        int_en,
  input  logic        dbg_mode,
  input  logic        halt_req,
  output logic [63:0] cnt,
  output logic [63:0] cmp,
  output logic        int_st,
  output logic        tim_int,
  output logic        halt_ack
);

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned HALF_W = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_state_e;

  halt_state_e        state_q;
  halt_state_e        state_d;
  logic               timer_en_q;
  logic               ten_fall;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cmp_d;
  logic               int_st_d;

  // Halt FSM next-state: hold off counting only while both qualifiers are high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (halt_req && dbg_mode)   state_d = ST_HALT;
      ST_HALT: if (!halt_req || !dbg_mode) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign halt_ack = (state_q == ST_HALT);

  // Counter / compare / status next-state.
  always_comb begin
    ten_fall = timer_en_q & ~timer_en;

    // Disable clear beats writes, writes beat increments.
    cnt_d = cnt;
    if (ten_fall) begin
      cnt_d = '0;
    end else if (wr_cnt_lo || wr_cnt_hi) begin
      if (wr_cnt_lo) cnt_d[HALF_W-1:0]     = wdata;
      if (wr_cnt_hi) cnt_d[CNT_W-1:HALF_W] = wdata;
    end else if (count_en && timer_en && !halt_ack) begin
      cnt_d = cnt + CNT_W'(1);
    end

    cmp_d = cmp;
    if (wr_cmp_lo) cmp_d[HALF_W-1:0]     = wdata;
    if (wr_cmp_hi) cmp_d[CNT_W-1:HALF_W] = wdata;

    // A live match re-sets the status even while software clears it.
    int_st_d = (cnt == cmp) | (int_st & ~(wr_int_st & wdata[0]));
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_RUN;
      timer_en_q <= 1'b0;
      cnt        <= '0;
      cmp        <= CMP_RST_VAL;
      int_st     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_en_q <= timer_en;
      cnt        <= cnt_d;
      cmp        <= cmp_d;
      int_st     <= int_st_d;
    end
  end

  assign tim_int = int_st & int_en;

endmodule

// File: tb/tb_timer_core.sv
module tb_timer_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        count_en, timer_en, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi;
  logic        wr_int_st, int_en, dbg_mode, halt_req;
  logic [31:0] wdata;
  logic [63:0] cnt, cmp;
  logic        int_st, tim_int, halt_ack;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_cnt, m_cmp;
  logic        m_int_st, m_halted, m_ten_prev;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  timer_core dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .count_en  (count_en),
    .timer_en  (timer_en),
    .wdata     (wdata),
    .wr_cnt_lo (wr_cnt_lo),
    .wr_cnt_hi (wr_cnt_hi),
    .wr_cmp_lo (wr_cmp_lo),
    .wr_cmp_hi (wr_cmp_hi),
    .wr_int_st (wr_int_st),
    .int_en    (int_en),
    .dbg_mode  (dbg_mode),
    .halt_req  (halt_req),
    .cnt       (cnt),
    .cmp       (cmp),
    .int_st    (int_st),
    .tim_int   (tim_int),
    .halt_ack  (halt_ack)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic idle_inputs();
    count_en = 0; wr_cnt_lo = 0; wr_cnt_hi = 0; wr_cmp_lo = 0; wr_cmp_hi = 0;
    wr_int_st = 0; wdata = 32'h0;
  endtask

  task automatic model_reset();
    m_cnt = 64'h0; m_cmp = ALL_ONES; m_int_st = 0; m_halted = 0; m_ten_prev = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // step the DUT through the same edge and settle.
  task automatic tick();
    logic [63:0] n_cnt, n_cmp;
    logic        matched;
    matched = (m_cnt == m_cmp);
    n_cnt = m_cnt;
    if (m_ten_prev && !timer_en)
      n_cnt = 64'h0;
    else if (wr_cnt_lo || wr_cnt_hi) begin
      n_cnt = {(wr_cnt_hi ? wdata : m_cnt[63:32]), (wr_cnt_lo ? wdata : m_cnt[31:0])};
    end else if (count_en && timer_en && !m_halted)
      n_cnt = m_cnt + 64'd1;
    n_cmp = {(wr_cmp_hi ? wdata : m_cmp[63:32]), (wr_cmp_lo ? wdata : m_cmp[31:0])};
    m_int_st   = matched || (m_int_st && !(wr_int_st && wdata[0]));
    m_halted   = halt_req && dbg_mode;
    m_ten_prev = timer_en;
    m_cnt = n_cnt;
    m_cmp = n_cmp;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst_n = 0;
    idle_inputs();
    timer_en = 0; int_en = 0; dbg_mode = 0; halt_req = 0;
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (cnt !== 64'h0 || cmp !== ALL_ONES || int_st !== 1'b0 || tim_int !== 1'b0 || halt_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: cnt=%h cmp=%h int_st=%b tim_int=%b halt_ack=%b, want 0/%h/0/0/0",
               cnt, cmp, int_st, tim_int, halt_ack, ALL_ONES);
    end
  endtask

  task automatic test_increment();
    apply_reset();
    timer_en = 1; count_en = 1;
    repeat (10) tick();
    count_en = 0;
    tick();
    checks++;
    if (cnt !== 64'd10 || cnt !== m_cnt) begin
      failures++;
      $display("FAIL increment: cnt=%h want %h", cnt, 64'd10);
    end
  endtask

  task automatic test_wrap_compare();
    apply_reset();
    timer_en = 1; int_en = 1;
    wr_cnt_lo = 1; wdata = 32'hFFFF_FFFE; tick(); idle_inputs();
    wr_cnt_hi = 1; wdata = 32'hFFFF_FFFF; tick(); idle_inputs();
    wr_cmp_lo = 1; wdata = 32'h0; tick(); idle_inputs();
    wr_cmp_hi = 1; wdata = 32'h0; tick(); idle_inputs();
    checks++;
    if (cnt !== 64'hFFFF_FFFF_FFFF_FFFE || cmp !== 64'h0) begin
      failures++;
      $display("FAIL wrap_setup: cnt=%h cmp=%h want fffffffffffffffe/0", cnt, cmp);
    end
    count_en = 1; tick(); count_en = 0; tick();
    count_en = 1; tick(); count_en = 0;
    checks++;
    if (cnt !== 64'h0 || int_st !== 1'b0) begin
      failures++;
      $display("FAIL wrap_to_zero: cnt=%h int_st=%b want 0/0", cnt, int_st);
    end
    tick();
    checks++;
    if (int_st !== 1'b1 || tim_int !== 1'b1 || m_int_st !== 1'b1) begin
      failures++;
      $display("FAIL compare_set: int_st=%b tim_int=%b want 1/1", int_st, tim_int);
    end
    int_en = 0; #1;
    checks++;
    if (tim_int !== 1'b0 || int_st !== 1'b1) begin
      failures++;
      $display("FAIL int_mask: tim_int=%b int_st=%b want 0/1", tim_int, int_st);
    end
  endtask

  task automatic test_write_vs_inc();
    apply_reset();
    timer_en = 1;
    wr_cnt_hi = 1; wdata = 32'h1; tick(); idle_inputs();
    wr_cnt_lo = 1; wdata = 32'h5; count_en = 1; tick(); idle_inputs();
    checks++;
    if (cnt !== 64'h1_0000_0005 || cnt !== m_cnt) begin
      failures++;
      $display("FAIL write_vs_inc: cnt=%h want %h", cnt, 64'h1_0000_0005);
    end
  endtask

  task automatic test_clear_vs_set();
    apply_reset();
    timer_en = 1;
    wr_cnt_lo = 1; wdata = 32'h5; tick(); idle_inputs();
    wr_cmp_lo = 1; wdata = 32'h5; tick(); idle_inputs();
    wr_cmp_hi = 1; wdata = 32'h0; tick(); idle_inputs();
    tick();
    checks++;
    if (int_st !== 1'b1) begin
      failures++;
      $display("FAIL match_set: int_st=%b want 1", int_st);
    end
    wr_int_st = 1; wdata = 32'h1; tick(); idle_inputs();
    checks++;
    if (int_st !== 1'b1) begin
      failures++;
      $display("FAIL set_beats_clear: int_st=%b want 1", int_st);
    end
    wr_cmp_lo = 1; wdata = 32'h9; tick(); idle_inputs();
    wr_int_st = 1; wdata = 32'h0; tick(); idle_inputs();
    checks++;
    if (int_st !== 1'b1) begin
      failures++;
      $display("FAIL clear_wdata0_zero: int_st=%b want 1", int_st);
    end
    wr_int_st = 1; wdata = 32'h1; tick(); idle_inputs();
    checks++;
    if (int_st !== 1'b0 || m_int_st !== 1'b0) begin
      failures++;
      $display("FAIL status_clear: int_st=%b want 0", int_st);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    timer_en = 1;
    wr_cnt_lo = 1; wdata = 32'h7; tick(); idle_inputs();
    dbg_mode = 1; halt_req = 1; count_en = 1; tick();
    checks++;
    if (halt_ack !== 1'b1 || cnt !== 64'd8) begin
      failures++;
      $display("FAIL halt_enter: halt_ack=%b cnt=%h want 1/8", halt_ack, cnt);
    end
    repeat (3) tick();
    checks++;
    if (cnt !== 64'd8 || halt_ack !== 1'b1) begin
      failures++;
      $display("FAIL halt_frozen: cnt=%h halt_ack=%b want 8/1", cnt, halt_ack);
    end
    halt_req = 0; count_en = 0; tick();
    checks++;
    if (halt_ack !== 1'b0 || cnt !== 64'd8) begin
      failures++;
      $display("FAIL halt_exit: halt_ack=%b cnt=%h want 0/8", halt_ack, cnt);
    end
    count_en = 1; tick(); count_en = 0;
    checks++;
    if (cnt !== 64'd9) begin
      failures++;
      $display("FAIL halt_resume: cnt=%h want 9", cnt);
    end
  endtask

  task automatic test_disable();
    apply_reset();
    timer_en = 1;
    wr_cnt_lo = 1; wdata = 32'd100; tick(); idle_inputs();
    timer_en = 0; wr_cnt_lo = 1; wdata = 32'd123; count_en = 1; tick(); idle_inputs();
    checks++;
    if (cnt !== 64'h0 || m_cnt !== 64'h0) begin
      failures++;
      $display("FAIL disable_clear: cnt=%h want 0", cnt);
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    timer_en = 1; count_en = 1; dbg_mode = 1; halt_req = 1; int_en = 1;
    wr_cmp_lo = 1; wdata = 32'h1; tick(); wr_cmp_lo = 0; tick(); tick();
    #2;
    sys_rst_n = 0;
    #1;
    checks++;
    if (cnt !== 64'h0 || cmp !== ALL_ONES || int_st !== 1'b0 || halt_ack !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: cnt=%h cmp=%h int_st=%b halt_ack=%b", cnt, cmp, int_st, halt_ack);
    end
    model_reset();
    halt_req = 0;
    @(negedge sys_clk);
    sys_rst_n = 1;
    tick();
    checks++;
    if (cnt !== 64'd1 || halt_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_resume: cnt=%h halt_ack=%b want 1/0", cnt, halt_ack);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    timer_en = 1;
    for (int i = 0; i < 600; i++) begin
      timer_en  = ($urandom_range(0, 19) != 0);
      count_en  = ($urandom_range(0, 1) == 1);
      wr_cnt_lo = ($urandom_range(0, 15) == 0);
      wr_cnt_hi = ($urandom_range(0, 15) == 0);
      wr_cmp_lo = ($urandom_range(0, 9) == 0);
      wr_cmp_hi = ($urandom_range(0, 9) == 0);
      wr_int_st = ($urandom_range(0, 7) == 0);
      int_en    = ($urandom_range(0, 1) == 1);
      dbg_mode  = ($urandom_range(0, 3) != 0);
      halt_req  = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 3);
      case (r)
        0: wdata = $urandom;
        1: wdata = 32'($urandom_range(0, 15));
        2: wdata = m_cnt[31:0] + 32'($urandom_range(0, 3));
        default: wdata = m_cnt[63:32];
      endcase
      tick();
      checks++;
      if (cnt !== m_cnt || cmp !== m_cmp || int_st !== m_int_st ||
          halt_ack !== m_halted || tim_int !== (m_int_st & int_en)) begin
        failures++;
        $display("FAIL random[%0d]: cnt=%h/%h cmp=%h/%h int_st=%b/%b halt=%b/%b tim_int=%b/%b",
                 i, cnt, m_cnt, cmp, m_cmp, int_st, m_int_st, halt_ack, m_halted,
                 tim_int, m_int_st & int_en);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_increment();
    test_wrap_compare();
    test_write_vs_inc();
    test_clear_vs_set();
    test_halt();
    test_disable();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
